// File: rtl/systolic_skew_feeder_if.sv
// AXI-Stream sample channel into the systolic skew feeder.
// Handshake: a beat transfers on a rising clock edge where tvalid && tready; the master holds tdata/tlast stable while tvalid is high and tready is low.
interface systolic_skew_feeder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Collects an AXI-Stream into N-element vectors and feeds them to the array rows with a k-cycle diagonal skew.
// Optional FEEDER_STATS_EN adds a 16-bit issued-vector counter output (vec_count).
module systolic_skew_feeder #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int CNT_W = 5
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    systolic_skew_feeder_if.slave  s_axis,
    output logic [N*WIDTH-1:0]     a_out,
    output logic [N-1:0]           a_valid,
    output logic                   done,
`ifdef FEEDER_STATS_EN
    output logic [15:0]            vec_count,
`endif
    output logic                   o_dbg_state
);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_drain;
    logic             r_tready;
    logic             r_done;
    logic [WIDTH-1:0] r_buf [0:N-2];

    logic             w_beat;
    logic             w_complete;
    logic             w_issue;
    logic [WIDTH-1:0] w_vec [0:N-1];

    assign s_axis.tready = r_tready;
    assign done          = r_done;
    assign o_dbg_state   = r_state;

    assign w_beat     = s_axis.tvalid && r_tready;
    assign w_complete = (r_cnt == CNT_W'(N-1)) || s_axis.tlast;
    assign w_issue    = w_beat && w_complete;

    // The completing beat bypasses the buffer; slots past it are zero padding.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_vec[i] = '0;
        end
        for (int i = 0; i < N-1; i++) begin
            if (CNT_W'(i) < r_cnt) begin
                w_vec[i] = r_buf[i];
            end else if (CNT_W'(i) == r_cnt) begin
                w_vec[i] = s_axis.tdata;
            end
        end
        if (r_cnt == CNT_W'(N-1)) begin
            w_vec[N-1] = s_axis.tdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= COLLECT;
            r_cnt    <= '0;
            r_drain  <= '0;
            r_tready <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < N-1; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                COLLECT: begin
                    r_tready <= 1'b1;
                    r_done   <= 1'b0;
                    if (w_beat) begin
                        if (w_complete) begin
                            r_cnt <= '0;
                            if (s_axis.tlast) begin
                                r_state  <= DRAIN;
                                r_tready <= 1'b0;
                                r_drain  <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            for (int i = 0; i < N-1; i++) begin
                                if (r_cnt == CNT_W'(i)) begin
                                    r_buf[i] <= s_axis.tdata;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    // done lines up with the last row of the final vector.
                    r_done <= (r_drain == CNT_W'(N-2));
                    if (r_drain == CNT_W'(N-1)) begin
                        r_state  <= COLLECT;
                        r_tready <= 1'b1;
                        r_drain  <= '0;
                    end else begin
                        r_drain <= r_drain + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    // Row k is a (k+1)-deep register line; idle slots carry zero data.
    for (genvar k = 0; k < N; k++) begin : g_row
        logic [WIDTH-1:0] r_d [0:k];
        logic [k:0]       r_v;

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                for (int j = 0; j <= k; j++) begin
                    r_d[j] <= '0;
                end
                r_v <= '0;
            end else begin
                r_d[0] <= w_issue ? w_vec[k] : '0;
                for (int j = 1; j <= k; j++) begin
                    r_d[j] <= r_d[j-1];
                end
                r_v <= (r_v << 1) | (k+1)'(w_issue);
            end
        end

        assign a_out[k*WIDTH +: WIDTH] = r_d[k];
        assign a_valid[k]              = r_v[k];
    end

`ifdef FEEDER_STATS_EN
    logic [15:0] r_vec_count;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_vec_count <= '0;
        end else if (w_issue) begin
            r_vec_count <= r_vec_count + 16'd1;
        end
    end

    assign vec_count = r_vec_count;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed table-driven bench for systolic_skew_feeder (N=4, WIDTH=16).
module tb_systolic_skew_feeder;
  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int CNT_W = 5;

  // clock / reset
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  systolic_skew_feeder_if #(.WIDTH(WIDTH)) s_axis_if ();

  logic [N*WIDTH-1:0] a_out;
  logic [N-1:0]       a_valid;
  logic               done;
  logic               dbg_state;
`ifdef FEEDER_STATS_EN
  logic [15:0]        vec_count;
`endif

  systolic_skew_feeder #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axis      (s_axis_if),
    .a_out       (a_out),
    .a_valid     (a_valid),
    .done        (done),
`ifdef FEEDER_STATS_EN
    .vec_count   (vec_count),
`endif
    .o_dbg_state (dbg_state)
  );

  typedef struct {
    logic [WIDTH-1:0]   tdata;
    logic               tvalid;
    logic               tlast;
    logic               exp_tready;
    logic [N-1:0]       exp_valid;
    logic [N*WIDTH-1:0] exp_out;
    logic               exp_done;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One table row: inputs for the next edge, outputs expected just after it (row < 0 = nothing valid).
  function automatic void add(input logic [WIDTH-1:0] d, input logic v, input logic l,
                              input logic tr, input int row, input logic [WIDTH-1:0] val,
                              input logic dn);
    vec_t r;
    r.tdata      = d;
    r.tvalid     = v;
    r.tlast      = l;
    r.exp_tready = tr;
    r.exp_valid  = (row >= 0) ? (N'(1) << row) : '0;
    r.exp_out    = (row >= 0) ? ((N*WIDTH)'(val) << (row*WIDTH)) : '0;
    r.exp_done   = dn;
    vecs.push_back(r);
  endfunction

  // driver
  task automatic apply(input vec_t r, input string tag);
    s_axis_if.tdata  = r.tdata;
    s_axis_if.tvalid = r.tvalid;
    s_axis_if.tlast  = r.tlast;
    @(posedge aclk);
    #1;
    check({tag, "_tready"}, 64'(s_axis_if.tready), 64'(r.exp_tready));
    check({tag, "_valid"},  64'(a_valid),          64'(r.exp_valid));
    check({tag, "_aout"},   64'(a_out),            64'(r.exp_out));
    check({tag, "_done"},   64'(done),             64'(r.exp_done));
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("%s%0d", name, i));
    end
    vecs.delete();
  endtask

  task automatic idle(input int cycles);
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tlast  = 1'b0;
    s_axis_if.tdata  = '0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    s_axis_if.tdata  = '0;
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tlast  = 1'b0;

    // reset state
    #1;
    check("rst_tready", 64'(s_axis_if.tready), 64'd0);
    check("rst_aout",   64'(a_out),            64'd0);
    check("rst_valid",  64'(a_valid),          64'd0);
    check("rst_done",   64'(done),             64'd0);
    check("rst_state",  64'(dbg_state),        64'd0);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("post_rst_tready", 64'(s_axis_if.tready), 64'd1);

    // 1..4 with tlast on 4: rows 1,2,3,4 in skew order, done with row 3
    add(16'd1, 1, 0, 1, -1, 16'd0, 0);
    add(16'd2, 1, 0, 1, -1, 16'd0, 0);
    add(16'd3, 1, 0, 1, -1, 16'd0, 0);
    add(16'd4, 1, 1, 0,  0, 16'd1, 0);
    add(16'd0, 0, 0, 0,  1, 16'd2, 0);
    add(16'd0, 0, 0, 0,  2, 16'd3, 0);
    add(16'd0, 0, 0, 0,  3, 16'd4, 1);
    add(16'd0, 0, 0, 1, -1, 16'd0, 0);
    run_table("t1_");

    // two back-to-back vectors, tvalid always high, tlast on beat 8
    add(16'h0400, 1, 0, 1, -1, 16'h0000, 0);
    add(16'h0500, 1, 0, 1, -1, 16'h0000, 0);
    add(16'h0600, 1, 0, 1, -1, 16'h0000, 0);
    add(16'h0700, 1, 0, 1,  0, 16'h0400, 0);
    add(16'h0800, 1, 0, 1,  1, 16'h0500, 0);
    add(16'h0900, 1, 0, 1,  2, 16'h0600, 0);
    add(16'h0A00, 1, 0, 1,  3, 16'h0700, 0);
    add(16'h0B00, 1, 1, 0,  0, 16'h0800, 0);
    add(16'h0000, 0, 0, 0,  1, 16'h0900, 0);
    add(16'h0000, 0, 0, 0,  2, 16'h0A00, 0);
    add(16'h0000, 0, 0, 0,  3, 16'h0B00, 1);
    add(16'h0000, 0, 0, 1, -1, 16'h0000, 0);
    run_table("t2_");

    // early tlast on beat 2: 5, -3, then zero padding still flagged valid
    add(16'h0005, 1, 0, 1, -1, 16'h0000, 0);
    add(16'hFFFD, 1, 1, 0,  0, 16'h0005, 0);
    add(16'h0000, 0, 0, 0,  1, 16'hFFFD, 0);
    add(16'h0000, 0, 0, 0,  2, 16'h0000, 0);
    add(16'h0000, 0, 0, 0,  3, 16'h0000, 1);
    add(16'h0000, 0, 0, 1, -1, 16'h0000, 0);
    run_table("t3_");

    // stalled vector, tvalid 1-0-0-1-1-0-1; idle cycles carry junk and a stray tlast
    add(16'h0011, 1, 0, 1, -1, 16'h0000, 0);
    add(16'hBAD0, 0, 0, 1, -1, 16'h0000, 0);
    add(16'hBAD1, 0, 1, 1, -1, 16'h0000, 0);
    add(16'h0022, 1, 0, 1, -1, 16'h0000, 0);
    add(16'h0033, 1, 0, 1, -1, 16'h0000, 0);
    add(16'hBAD2, 0, 0, 1, -1, 16'h0000, 0);
    add(16'h0044, 1, 1, 0,  0, 16'h0011, 0);
    add(16'h0000, 0, 0, 0,  1, 16'h0022, 0);
    add(16'h0000, 0, 0, 0,  2, 16'h0033, 0);
    add(16'h0000, 0, 0, 0,  3, 16'h0044, 1);
    add(16'h0000, 0, 0, 1, -1, 16'h0000, 0);
    run_table("t4_");

    // tlast on the first element: {sample, 0, 0, 0}
    add(16'h1234, 1, 1, 0,  0, 16'h1234, 0);
    add(16'h0000, 0, 0, 0,  1, 16'h0000, 0);
    add(16'h0000, 0, 0, 0,  2, 16'h0000, 0);
    add(16'h0000, 0, 0, 0,  3, 16'h0000, 1);
    add(16'h0000, 0, 0, 1, -1, 16'h0000, 0);
    run_table("t5_");

`ifdef FEEDER_STATS_EN
    check("stats_after_table", 64'(vec_count), 64'd6);
`endif

    // full vector without tlast, then asynchronous reset two cycles after its issue
    add(16'h00A1, 1, 0, 1, -1, 16'h0000, 0);
    add(16'h00A2, 1, 0, 1, -1, 16'h0000, 0);
    add(16'h00A3, 1, 0, 1, -1, 16'h0000, 0);
    add(16'h00A4, 1, 0, 1,  0, 16'h00A1, 0);
    add(16'h00B1, 1, 0, 1,  1, 16'h00A2, 0);
    run_table("t6_");
`ifdef FEEDER_STATS_EN
    check("stats_before_rst", 64'(vec_count), 64'd7);
`endif
    s_axis_if.tvalid = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_aout",   64'(a_out),            64'd0);
    check("mid_rst_valid",  64'(a_valid),          64'd0);
    check("mid_rst_tready", 64'(s_axis_if.tready), 64'd0);
    check("mid_rst_done",   64'(done),             64'd0);
    check("mid_rst_state",  64'(dbg_state),        64'd0);
`ifdef FEEDER_STATS_EN
    check("stats_rst", 64'(vec_count), 64'd0);
`endif
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("post_rst%0d_valid", i), 64'(a_valid), 64'd0);
      check($sformatf("post_rst%0d_done", i),  64'(done),     64'd0);
      idle(1);
    end

    // clean vector after the aborted one
    add(16'h00C1, 1, 0, 1, -1, 16'h0000, 0);
    add(16'h00C2, 1, 0, 1, -1, 16'h0000, 0);
    add(16'h00C3, 1, 0, 1, -1, 16'h0000, 0);
    add(16'h00C4, 1, 1, 0,  0, 16'h00C1, 0);
    add(16'h0000, 0, 0, 0,  1, 16'h00C2, 0);
    add(16'h0000, 0, 0, 0,  2, 16'h00C3, 0);
    add(16'h0000, 0, 0, 0,  3, 16'h00C4, 1);
    add(16'h0000, 0, 0, 1, -1, 16'h0000, 0);
    run_table("t7_");

`ifdef FEEDER_STATS_EN
    // two more vectors (one full, one padded) make three since reset
    for (int i = 0; i < 6; i++) begin
      s_axis_if.tdata  = WIDTH'(16'h0100 + i);
      s_axis_if.tvalid = 1'b1;
      s_axis_if.tlast  = (i == 5);
      @(posedge aclk);
      #1;
    end
    idle(N + 1);
    check("stats_three", 64'(vec_count), 64'd3);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog: the directed sequence is a few hundred cycles at most
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
